// File: rtl/extensor_de_sinal.sv
// -----------------------------------------------------------------------------
// extensor_de_sinal
//
// Widens an IN_W-bit immediate/offset field to an OUT_W-bit word by
// replicating its top bit. Offers:
//   - a zero-latency combinational result for the single-cycle datapath;
//   - a one-stage registered copy qualified by a valid flag;
//   - a registered word-offset copy (extended value shifted left by 2) for
//     the branch target adder.
//
// Parameters:
//   IN_W   input field width (>= 2 and < OUT_W)
//   OUT_W  output word width
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   zext       in   1      (EXTENSOR_ZERO_EXT_EN only) 1 = zero-extend In
//   In         in   IN_W   immediate field to extend
//   in_valid   in   1      qualifies In for capture into the registered stage
//   Out        out  OUT_W  combinational extension of In
//   out_reg    out  OUT_W  registered extension of the last valid In
//   out_shl2   out  OUT_W  registered extension shifted left by 2
//   out_valid  out  1      high for one cycle after each captured In
//
// Optional feature: define EXTENSOR_ZERO_EXT_EN to add the zext input, which
// forces the upper bits of the extension to zero (andi/ori/xori immediates).
// The registered outputs capture Out, so zext affects them as well.
// -----------------------------------------------------------------------------
module extensor_de_sinal #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
`ifdef EXTENSOR_ZERO_EXT_EN
    input  logic             zext,
`endif
    input  logic [IN_W-1:0]  In,
    input  logic             in_valid,
    output logic [OUT_W-1:0] Out,
    output logic [OUT_W-1:0] out_reg,
    output logic [OUT_W-1:0] out_shl2,
    output logic             out_valid
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic             fill;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] shl2_d;

    logic [OUT_W-1:0] out_reg_q;
    logic [OUT_W-1:0] out_shl2_q;
    logic             out_valid_q;

    // Extension: the fill bit is the field's sign bit unless zero-extension
    // is requested.
    always_comb begin
        fill = In[IN_W-1];
`ifdef EXTENSOR_ZERO_EXT_EN
        if (zext) begin
            fill = 1'b0;
        end
`endif
        ext    = {{EXT_W{fill}}, In};
        // Word offset: the top two bits of the extension fall off the end.
        shl2_d = {ext[OUT_W-3:0], 2'b00};
    end

    assign Out = ext;

    // Registered stage: reset wins over in_valid; values hold while idle but
    // the valid flag only marks the cycle right after a capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg_q   <= '0;
            out_shl2_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_reg_q  <= ext;
                out_shl2_q <= shl2_d;
            end
        end
    end

    assign out_reg   = out_reg_q;
    assign out_shl2  = out_shl2_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_extensor_de_sinal.sv
// -----------------------------------------------------------------------------
// tb_extensor_de_sinal
//
// Self-checking bench for extensor_de_sinal (default widths 16 -> 32).
// Directed scenarios cover the documented examples, boundaries, registered
// timing, back-to-back capture and reset priority; a randomized run compares
// every cycle against an arithmetic reference (two's-complement value of the
// field, times four for the word offset).
// -----------------------------------------------------------------------------
module tb_extensor_de_sinal;

    logic        clock;
    logic        reset;
    logic [15:0] In;
    logic        in_valid;
    logic [31:0] Out;
    logic [31:0] out_reg;
    logic [31:0] out_shl2;
    logic        out_valid;
    logic        zv;

    int tests;
    int fails;

    // Reference model state for the registered outputs.
    logic [31:0] m_reg;
    logic [31:0] m_shl2;
    logic        m_valid;

    extensor_de_sinal #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef EXTENSOR_ZERO_EXT_EN
        .zext      (zv),
`endif
        .In        (In),
        .in_valid  (in_valid),
        .Out       (Out),
        .out_reg   (out_reg),
        .out_shl2  (out_shl2),
        .out_valid (out_valid)
    );

    always #5 clock = ~clock;

    // Numeric meaning of the field: unsigned when zero-extending, otherwise
    // two's complement.
    function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic z);
        longint s;
        s = longint'(v);
        if (!z && v >= 16'h8000) s = s - 65536;
        return 32'(s);
    endfunction

    function automatic logic [31:0] ref_shl2(input logic [15:0] v, input logic z);
        longint s;
        s = longint'(ref_ext(v, z));
        return 32'(s * 4);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        In       = 16'h1234;
        tick();
        tick();
        tests++;
        if (out_reg !== 32'h0) begin
            fails++;
            $display("FAIL reset_out_reg got=%h exp=%h", out_reg, 32'h0);
        end
        tests++;
        if (out_shl2 !== 32'h0) begin
            fails++;
            $display("FAIL reset_out_shl2 got=%h exp=%h", out_shl2, 32'h0);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        tests++;
        if (Out !== 32'h00001234) begin
            fails++;
            $display("FAIL reset_comb_out got=%h exp=%h", Out, 32'h00001234);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_comb_sweep();
        logic [15:0] vin [9];
        logic [31:0] vexp[9];
        vin  = '{16'h0000, 16'h8000, 16'h8001, 16'hE000, 16'h000F,
                 16'h0018, 16'h7FFF, 16'hFFFF, 16'h0001};
        vexp = '{32'h00000000, 32'hFFFF8000, 32'hFFFF8001, 32'hFFFFE000,
                 32'h0000000F, 32'h00000018, 32'h00007FFF, 32'hFFFFFFFF,
                 32'h00000001};
        for (int i = 0; i < 9; i++) begin
            In = vin[i];
            #1;
            tests++;
            if (Out !== vexp[i]) begin
                fails++;
                $display("FAIL comb_sweep in=%h got=%h exp=%h", vin[i], Out, vexp[i]);
            end
        end
    endtask

    task automatic test_registered();
        In       = 16'hFFFC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        In       = 16'h1111;
        tests++;
        if (out_reg !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL reg_capture got=%h exp=%h", out_reg, 32'hFFFFFFFC);
        end
        tests++;
        if (out_shl2 !== 32'hFFFFFFF0) begin
            fails++;
            $display("FAIL reg_shl2 got=%h exp=%h", out_shl2, 32'hFFFFFFF0);
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reg_valid got=%b exp=1", out_valid);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_reg !== 32'hFFFFFFFC || out_shl2 !== 32'hFFFFFFF0) begin
            fails++;
            $display("FAIL reg_hold got=%b/%h/%h exp=0/fffffffc/fffffff0",
                     out_valid, out_reg, out_shl2);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        In       = 16'h0004;
        tick();
        In = 16'h8000;
        tests++;
        if (out_valid !== 1'b1 || out_reg !== 32'h00000004 || out_shl2 !== 32'h00000010) begin
            fails++;
            $display("FAIL b2b_first got=%b/%h/%h exp=1/00000004/00000010",
                     out_valid, out_reg, out_shl2);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_reg !== 32'hFFFF8000 || out_shl2 !== 32'hFFFE0000) begin
            fails++;
            $display("FAIL b2b_second got=%b/%h/%h exp=1/ffff8000/fffe0000",
                     out_valid, out_reg, out_shl2);
        end
        tick();
    endtask

    task automatic test_reset_priority();
        reset    = 1'b1;
        in_valid = 1'b1;
        In       = 16'h1234;
        #1;
        tests++;
        if (Out !== 32'h00001234) begin
            fails++;
            $display("FAIL rstprio_comb got=%h exp=%h", Out, 32'h00001234);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_reg !== 32'h0 || out_shl2 !== 32'h0) begin
            fails++;
            $display("FAIL rstprio_regs got=%b/%h/%h exp=0/00000000/00000000",
                     out_valid, out_reg, out_shl2);
        end
        reset = 1'b0;
        In    = 16'h0018;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_reg !== 32'h00000018 || out_shl2 !== 32'h00000060) begin
            fails++;
            $display("FAIL rstprio_recover got=%b/%h/%h exp=1/00000018/00000060",
                     out_valid, out_reg, out_shl2);
        end
        tick();
    endtask

`ifdef EXTENSOR_ZERO_EXT_EN
    task automatic test_zext();
        In = 16'h8000;
        zv = 1'b1;
        #1;
        tests++;
        if (Out !== 32'h00008000) begin
            fails++;
            $display("FAIL zext_on got=%h exp=%h", Out, 32'h00008000);
        end
        zv = 1'b0;
        #1;
        tests++;
        if (Out !== 32'hFFFF8000) begin
            fails++;
            $display("FAIL zext_off got=%h exp=%h", Out, 32'hFFFF8000);
        end
        zv       = 1'b1;
        In       = 16'hFFFC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        zv       = 1'b0;
        tests++;
        if (out_reg !== 32'h0000FFFC || out_shl2 !== 32'h0003FFF0) begin
            fails++;
            $display("FAIL zext_reg got=%h/%h exp=0000fffc/0003fff0", out_reg, out_shl2);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] e;
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        m_reg   = '0;
        m_shl2  = '0;
        m_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 15) == 0);
            in_valid = 1'(($urandom_range(0, 3) != 0));
            In       = 16'($urandom);
`ifdef EXTENSOR_ZERO_EXT_EN
            zv = 1'($urandom_range(0, 1));
`endif
            #1;
            e = ref_ext(In, zv);
            tests++;
            if (Out !== e) begin
                fails++;
                $display("FAIL rand_comb i=%0d in=%h got=%h exp=%h", i, In, Out, e);
            end
            if (reset) begin
                m_reg   = '0;
                m_shl2  = '0;
                m_valid = 1'b0;
            end else if (in_valid) begin
                m_reg   = e;
                m_shl2  = ref_shl2(In, zv);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            tick();
            tests++;
            if (out_reg !== m_reg || out_shl2 !== m_shl2 || out_valid !== m_valid) begin
                fails++;
                $display("FAIL rand_reg i=%0d got=%b/%h/%h exp=%b/%h/%h", i,
                         out_valid, out_reg, out_shl2, m_valid, m_reg, m_shl2);
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        zv       = 1'b0;
    endtask

    initial begin
        clock    = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        In       = '0;
        zv       = 1'b0;
        tests    = 0;
        fails    = 0;
        test_reset();
        test_comb_sweep();
        test_registered();
        test_back_to_back();
        test_reset_priority();
`ifdef EXTENSOR_ZERO_EXT_EN
        test_zext();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/extensor_de_sinal.md
Name: extensor_de_sinal

Overview:
- Sign extender for the MIPS-style datapath: widens a 16-bit immediate/offset field to a 32-bit word by replicating bit 15.
- Provides a combinational result for the single-cycle datapath, plus a one-stage registered copy with valid and a word-offset (shift-left-2) variant for branch target computation.
- Sits between instruction-field decode and the ALU B-operand / branch adder muxes.

Parameters:
- IN_W, 16, input field width; must be >= 2 and < OUT_W.
- OUT_W, 32, output word width.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- In  input  IN_W  immediate field to extend.
- in_valid  input  1  qualifies In for capture into the registered stage.
- Out  output  OUT_W  combinational extension of In.
- out_reg  output  OUT_W  registered extension of the last valid In.
- out_shl2  output  OUT_W  registered extension shifted left by 2 (branch word offset).
- out_valid  output  1  high when out_reg/out_shl2 hold a freshly captured value.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Combinational path:
  - Out[IN_W-1:0] = In.
  - Out[OUT_W-1:IN_W] = replicated In[IN_W-1].
  - Zero latency; independent of clock and reset. Out is valid during reset.
- Examples (defaults):
  - 16'h0000 -> 32'h00000000
  - 16'h8000 -> 32'hFFFF8000
  - 16'h8001 -> 32'hFFFF8001
  - 16'hE000 -> 32'hFFFFE000
  - 16'h000F -> 32'h0000000F
  - 16'h0018 -> 32'h00000018
  - 16'h7FFF -> 32'h00007FFF
  - 16'hFFFF -> 32'hFFFFFFFF
- Registered path, on rising edge of clock:
  - reset = 1: out_reg = 0, out_shl2 = 0, out_valid = 0. Reset overrides in_valid in the same cycle.
  - reset = 0 and in_valid = 1: out_reg = Out, out_shl2 = {Out[OUT_W-3:0], 2'b00}, out_valid = 1.
  - reset = 0 and in_valid = 0: out_reg and out_shl2 hold; out_valid = 0.
  - Latency: 1 cycle from in_valid to out_valid.
  - Back-to-back in_valid is accepted every cycle. There is no backpressure and no ready signal.
- out_shl2: the top 2 bits of the extended value are discarded. No overflow flag.
- Reset asserted mid-stream clears the registered outputs on that edge; the following in_valid captures normally.
- No X propagation from the registered outputs after the first reset edge.

Optional Feature:
- Macro: EXTENSOR_ZERO_EXT_EN.
- Defined:
  - Adds input port zext (1 bit).
  - When zext = 1, the upper bits of Out are forced to 0 (unsigned immediates for andi/ori/xori).
  - When zext = 0, behaviour is normal sign extension.
  - zext also affects the registered outputs, because they capture Out.
- Not defined:
  - Port zext does not exist.
  - Always sign-extends.

Test Plan:
- Combinational sweep: apply In = 0000, 8000, 8001, E000, 000F, 0018, check Out after settle -> 00000000, FFFF8000, FFFF8001, FFFFE000, 0000000F, 00000018.
- Boundaries: In = 7FFF -> Out 00007FFF; In = FFFF -> Out FFFFFFFF; In = 0001 -> Out 00000001.
- Registered path: reset 2 cycles (outputs 0, out_valid 0), then in_valid = 1 with In = FFFC for 1 cycle -> next edge out_reg = FFFFFFFC, out_shl2 = FFFFFFF0, out_valid = 1; following idle cycle -> out_valid = 0, values held.
- Back-to-back: in_valid held high with In = 0004 then 8000 -> out_reg 00000004 then FFFF8000; out_shl2 00000010 then FFFE0000; out_valid stays 1.
- Reset priority: reset = 1 and in_valid = 1 with In = 1234 on the same edge -> out_reg 0, out_valid 0; Out still 00001234.
- With EXTENSOR_ZERO_EXT_EN: zext = 1, In = 8000 -> Out 00008000; zext = 0, In = 8000 -> Out FFFF8000.
